// File: rtl/stash_read_scheduler_pkg.sv
// Shared types and helpers for the stash read/write-back schedulers:
// FSM state encoding and the (leaf, level) -> heap bucket index mapping.
package stash_read_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Heap index of the bucket at level lvl on the path to leaf.
  // Levels past the leaf return only the level base; callers never use them.
  function automatic logic [31:0] bucket_idx(input logic [31:0] leaf,
                                             input int lvl,
                                             input int oraml);
    logic [31:0] base;
    base = (32'd1 << lvl) - 32'd1;
    if (lvl > oraml) return base;
    return base + (leaf >> (oraml - lvl));
  endfunction

endpackage

// File: rtl/stash_read_scheduler_bucket_counter.sv
// Return-side bookkeeping: chunk counter within a bucket, buckets outstanding,
// buckets returned for the current access, and the sticky protocol error.
module stash_bucket_counter #(
  parameter int BktSize = 8,
  parameter int OutW    = 3,
  parameter int RetW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_ret,
  input  logic            issue_fire,
  input  logic            data_fire,
  output logic [OutW-1:0] outstanding,
  output logic [RetW-1:0] returned,
  output logic [RetW-1:0] returned_nxt,
  output logic            proto_err
);
  localparam int CW = (BktSize > 1) ? $clog2(BktSize) : 1;

  logic [CW-1:0]   chunk_cnt_q, chunk_cnt_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic [RetW-1:0] returned_q, returned_d;
  logic            proto_err_q, proto_err_d;
  logic            chunk_ok, wrap;

  always_comb begin
    // A chunk with nothing outstanding is dropped and flagged, never counted.
    chunk_ok      = data_fire && (outstanding_q != '0);
    wrap          = chunk_ok && (chunk_cnt_q == CW'(BktSize - 1));
    chunk_cnt_d   = chunk_cnt_q;
    if (chunk_ok) chunk_cnt_d = wrap ? '0 : chunk_cnt_q + 1'b1;
    outstanding_d = outstanding_q + OutW'(issue_fire) - OutW'(wrap);
    returned_d    = clear_ret ? '0 : returned_q + RetW'(wrap);
    proto_err_d   = proto_err_q | (data_fire && (outstanding_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_cnt_q   <= '0;
      outstanding_q <= '0;
      returned_q    <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      chunk_cnt_q   <= chunk_cnt_d;
      outstanding_q <= outstanding_d;
      returned_q    <= returned_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign outstanding  = outstanding_q;
  assign returned     = returned_q;
  assign returned_nxt = returned_d;
  assign proto_err    = proto_err_q;
endmodule

// File: rtl/stash_read_scheduler.sv
// Read-side path access sequencer: issues bucket reads root to leaf under an
// outstanding limit and pulses PathDone once all data returns.
// Optional STASH_SCHED_PERF_EN adds the PerfCycles busy-cycle counter output.
module stash_read_scheduler
  import stash_read_scheduler_pkg::*;
#(
  parameter int ORAML             = 10,
  parameter int BktSize_BEDChunks = 8,
  parameter int MaxOutstanding    = 4,
  parameter int BAWidth           = ORAML + 1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [ORAML-1:0]           CmdLeaf,
  input  logic                       CmdRO,
  input  logic [$clog2(ORAML+1)-1:0] CmdLevel,
  input  logic                       CmdValid,
  output logic                       CmdReady,
  output logic [BAWidth-1:0]         DRAMCmdBucket,
  output logic                       DRAMCmdValid,
  input  logic                       DRAMCmdReady,
  input  logic                       DataFire,
  output logic                       PathDone,
  output logic                       Busy,
  output logic                       ProtocolError
`ifdef STASH_SCHED_PERF_EN
  ,
  output logic [31:0]                PerfCycles
`endif
);
  localparam int LvlW = $clog2(ORAML + 1);
  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam int CntW = $clog2(ORAML + 2);

  sched_state_e     state_q, state_d;
  logic [ORAML-1:0] leaf_q, leaf_d;
  logic [LvlW-1:0]  lvl_q, lvl_d;
  logic [CntW-1:0]  issued_q, issued_d;
  logic [CntW-1:0]  total_q, total_d;
  logic [BAWidth-1:0] bucket_q, bucket_d;
  logic [OutW-1:0]  outstanding;
  logic [CntW-1:0]  returned, returned_nxt;
  logic             cmd_fire, dram_fire;

  assign cmd_fire  = (state_q == ST_IDLE) && CmdValid;
  assign dram_fire = DRAMCmdValid && DRAMCmdReady;

  stash_bucket_counter #(
    .BktSize (BktSize_BEDChunks),
    .OutW    (OutW),
    .RetW    (CntW)
  ) u_cnt (
    .clk          (Clock),
    .rst          (Reset),
    .clear_ret    (cmd_fire),
    .issue_fire   (dram_fire),
    .data_fire    (DataFire),
    .outstanding  (outstanding),
    .returned     (returned),
    .returned_nxt (returned_nxt),
    .proto_err    (ProtocolError)
  );

  always_comb begin
    state_d      = state_q;
    leaf_d       = leaf_q;
    lvl_d        = lvl_q;
    issued_d     = issued_q;
    total_d      = total_q;
    bucket_d     = bucket_q;
    CmdReady     = 1'b0;
    DRAMCmdValid = 1'b0;
    PathDone     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        CmdReady = 1'b1;
        if (CmdValid) begin
          leaf_d   = CmdLeaf;
          lvl_d    = CmdRO ? CmdLevel : '0;
          total_d  = CmdRO ? CntW'(1) : CntW'(ORAML + 1);
          issued_d = '0;
          bucket_d = BAWidth'(bucket_idx(32'(CmdLeaf), int'(lvl_d), ORAML));
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        DRAMCmdValid = (outstanding < OutW'(MaxOutstanding));
        // Bucket register advances only on a fire, so it holds under stall.
        if (DRAMCmdValid && DRAMCmdReady) begin
          issued_d = issued_q + 1'b1;
          lvl_d    = lvl_q + 1'b1;
          bucket_d = BAWidth'(bucket_idx(32'(leaf_q), int'(lvl_q) + 1, ORAML));
          if (issued_d == total_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Look at the next returned count so PathDone follows the last chunk by one cycle.
        if (returned_nxt == total_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        PathDone = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      leaf_q   <= '0;
      lvl_q    <= '0;
      issued_q <= '0;
      total_q  <= '0;
      bucket_q <= '0;
    end else begin
      state_q  <= state_d;
      leaf_q   <= leaf_d;
      lvl_q    <= lvl_d;
      issued_q <= issued_d;
      total_q  <= total_d;
      bucket_q <= bucket_d;
    end
  end

  assign DRAMCmdBucket = bucket_q;
  assign Busy          = (state_q != ST_IDLE);

`ifdef STASH_SCHED_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d, perf_out_q, perf_out_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (cmd_fire)  perf_cnt_d = '0;
    else if (Busy) perf_cnt_d = perf_cnt_q + 32'd1;
    // Snapshot includes the DONE cycle itself.
    perf_out_d = (state_q == ST_DONE) ? perf_cnt_q + 32'd1 : perf_out_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      perf_cnt_q <= '0;
      perf_out_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      perf_out_q <= perf_out_d;
    end
  end

  assign PerfCycles = perf_out_q;
`endif
endmodule

// File: tb/tb_stash_read_scheduler.sv
// Self-checking bench: table of accesses with expected bucket sequences fed
// through a scoreboard queue, plus hand-written reset/protocol/limit sequences.
module tb_stash_read_scheduler;
  localparam int ORAML = 3;
  localparam int BKT   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] a_leaf = '0;
  logic       a_ro = 1'b0, a_cvalid = 1'b0, a_cready;
  logic [1:0] a_lvl = '0;
  logic [3:0] a_bkt;
  logic       a_dvalid, a_dready = 1'b1, a_df = 1'b0, a_pd, a_busy, a_perr;

  logic [2:0] b_leaf = '0;
  logic       b_ro = 1'b0, b_cvalid = 1'b0, b_cready;
  logic [1:0] b_lvl = '0;
  logic [3:0] b_bkt;
  logic       b_dvalid, b_dready = 1'b1, b_df = 1'b0, b_pd, b_busy, b_perr;

  stash_read_scheduler #(.ORAML(ORAML), .BktSize_BEDChunks(BKT), .MaxOutstanding(4)) dut_a (
    .Clock(clk), .Reset(rst), .CmdLeaf(a_leaf), .CmdRO(a_ro), .CmdLevel(a_lvl),
    .CmdValid(a_cvalid), .CmdReady(a_cready), .DRAMCmdBucket(a_bkt),
    .DRAMCmdValid(a_dvalid), .DRAMCmdReady(a_dready), .DataFire(a_df),
    .PathDone(a_pd), .Busy(a_busy), .ProtocolError(a_perr));

  stash_read_scheduler #(.ORAML(ORAML), .BktSize_BEDChunks(BKT), .MaxOutstanding(2)) dut_b (
    .Clock(clk), .Reset(rst), .CmdLeaf(b_leaf), .CmdRO(b_ro), .CmdLevel(b_lvl),
    .CmdValid(b_cvalid), .CmdReady(b_cready), .DRAMCmdBucket(b_bkt),
    .DRAMCmdValid(b_dvalid), .DRAMCmdReady(b_dready), .DataFire(b_df),
    .PathDone(b_pd), .Busy(b_busy), .ProtocolError(b_perr));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct packed {
    logic           ro;
    logic [2:0]     leaf;
    logic [1:0]     lvl;
    logic [2:0]     n;
    logic [3:0][3:0] exp;
    logic [2:0]     stall_after;
    logic [2:0]     stall_len;
  } vec_t;

  function automatic vec_t mk(input logic ro, input logic [2:0] leaf, input logic [1:0] lvl,
                              input logic [2:0] n, input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3,
                              input logic [2:0] sa, input logic [2:0] sl);
    vec_t v;
    v.ro = ro; v.leaf = leaf; v.lvl = lvl; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.stall_after = sa; v.stall_len = sl;
    return v;
  endfunction

  // Scoreboard and data-return model for dut_a.
  logic [3:0] exp_q[$];
  int  pend = 0, fires = 0, chunks = 0, cyc = 0, last_df_cyc = -10;
  int  stall_after = -1, stall_left = 0;
  bit  data_en = 1'b0, done_seen = 1'b0, held = 1'b0, inj_df = 1'b0;
  logic [3:0] held_bkt = '0;

  always @(negedge clk) begin
    cyc++;
    if (held) begin
      chk("stall_valid", {31'd0, a_dvalid}, 32'd1);
      chk("stall_bucket", {28'd0, a_bkt}, {28'd0, held_bkt});
    end
    if (a_pd === 1'b1) begin
      done_seen = 1'b1;
      chk("pathdone_latency", cyc - last_df_cyc, 32'd1);
      chk("pathdone_queue_empty", exp_q.size(), 32'd0);
    end
    a_df = 1'b0;
    if (inj_df) begin
      a_df = 1'b1;
      inj_df = 1'b0;
    end else if (data_en && pend > 0) begin
      a_df = 1'b1;
      pend--;
      chunks++;
      last_df_cyc = cyc;
    end
    if (stall_after == fires && stall_left > 0) begin
      a_dready = 1'b0;
      stall_left--;
    end else a_dready = 1'b1;
    held = (a_dvalid === 1'b1) && !a_dready;
    held_bkt = a_bkt;
    if (a_dvalid === 1'b1 && a_dready) begin
      fires++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fire: got bucket %0d expected none", a_bkt);
      end else chk("bucket", {28'd0, a_bkt}, {28'd0, exp_q.pop_front()});
      pend += BKT;
    end
  end

  task automatic run_access(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) exp_q.push_back(v.exp[i]);
    fires = 0; chunks = 0; done_seen = 1'b0; data_en = 1'b1;
    stall_after = int'(v.stall_after); stall_left = int'(v.stall_len);
    chk("cmd_ready_idle", {31'd0, a_cready}, 32'd1);
    a_ro = v.ro; a_leaf = v.leaf; a_lvl = v.lvl; a_cvalid = 1'b1;
    @(negedge clk);
    a_cvalid = 1'b0;
    chk("first_issue_latency", {31'd0, a_dvalid}, 32'd1);
    chk("busy", {31'd0, a_busy}, 32'd1);
    for (int c = 0; c < 500 && !done_seen; c++) @(negedge clk);
    chk("pathdone_seen", {31'd0, done_seen}, 32'd1);
    chk("chunks", chunks, int'(v.n) * BKT);
    chk("fires", fires, int'(v.n));
    @(negedge clk);
    chk("pathdone_one_cycle", {31'd0, a_pd}, 32'd0);
    chk("ready_after_done", {31'd0, a_cready}, 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(1'b0, 3'd5, 2'd0, 3'd4, 4'd0, 4'd2, 4'd5, 4'd12, 3'd0, 3'd0);
    vecs[1] = mk(1'b1, 3'd5, 2'd2, 3'd1, 4'd5, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
    vecs[2] = mk(1'b0, 3'd7, 2'd0, 3'd4, 4'd0, 4'd2, 4'd6, 4'd14, 3'd1, 3'd5);
    vecs[3] = mk(1'b0, 3'd0, 2'd0, 3'd4, 4'd0, 4'd1, 4'd3, 4'd7, 3'd0, 3'd0);
    vecs[4] = mk(1'b1, 3'd6, 2'd3, 3'd1, 4'd13, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
    vecs[5] = mk(1'b1, 3'd3, 2'd0, 3'd1, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);
    vecs[6] = mk(1'b1, 3'd4, 2'd1, 3'd1, 4'd2, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, a_cready}, 32'd1);
    chk("rst_dram_valid", {31'd0, a_dvalid}, 32'd0);
    chk("rst_pathdone", {31'd0, a_pd}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_proto_err", {31'd0, a_perr}, 32'd0);
    chk("rst_b_cmd_ready", {31'd0, b_cready}, 32'd1);

    for (int i = 0; i < 7; i++) run_access(vecs[i]);

    // Stray chunk while idle: sticky error, chunk not counted.
    inj_df = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("proto_err_set", {31'd0, a_perr}, 32'd1);
    chk("idle_after_stray", {31'd0, a_busy}, 32'd0);
    run_access(vecs[0]);
    chk("proto_err_sticky", {31'd0, a_perr}, 32'd1);

    // Reset mid-access after two buckets issued.
    data_en = 1'b0; done_seen = 1'b0; fires = 0;
    stall_after = -1; stall_left = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(vecs[0].exp[i]);
    a_ro = 1'b0; a_leaf = 3'd5; a_lvl = 2'd0; a_cvalid = 1'b1;
    @(negedge clk);
    a_cvalid = 1'b0;
    for (int c = 0; c < 50 && fires < 2; c++) @(negedge clk);
    chk("two_issued_before_reset", fires, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    pend = 0;
    chk("post_rst_cmd_ready", {31'd0, a_cready}, 32'd1);
    chk("post_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("post_rst_dram_valid", {31'd0, a_dvalid}, 32'd0);
    chk("post_rst_proto_err", {31'd0, a_perr}, 32'd0);
    repeat (4) @(negedge clk);
    chk("no_pathdone_after_rst", {31'd0, done_seen}, 32'd0);
    run_access(vecs[2]);

    // Outstanding limit of 2 with no data returned.
    b_ro = 1'b0; b_leaf = 3'd0; b_lvl = 2'd0; b_cvalid = 1'b1;
    @(negedge clk);
    b_cvalid = 1'b0;
    chk("lim_first_valid", {31'd0, b_dvalid}, 32'd1);
    chk("lim_bucket0", {28'd0, b_bkt}, 32'd0);
    @(negedge clk);
    chk("lim_second_valid", {31'd0, b_dvalid}, 32'd1);
    chk("lim_bucket1", {28'd0, b_bkt}, 32'd1);
    @(negedge clk);
    chk("lim_blocked", {31'd0, b_dvalid}, 32'd0);
    @(negedge clk);
    chk("lim_still_blocked", {31'd0, b_dvalid}, 32'd0);
    b_df = 1'b1;
    repeat (7) @(negedge clk);
    chk("lim_blocked_7_chunks", {31'd0, b_dvalid}, 32'd0);
    @(negedge clk);
    b_df = 1'b0;
    chk("lim_resume_valid", {31'd0, b_dvalid}, 32'd1);
    chk("lim_bucket3", {28'd0, b_bkt}, 32'd3);
    chk("lim_proto_err", {31'd0, b_perr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
